gate_truth_table_checker: RTL and testbench
===========================================

Name: gate_truth_table_checker

Overview:
Hardware stimulus/response engine for 2-input gate DUTs. It drives the DUT's a/b inputs through all four combinations, samples the DUT output y after a settle window, and compares y against an expected truth table. It reports a per-vector fail mask, an error count and pass/done flags. It sits beside the gate under test and replaces a simulation-only monitor, so gate blocks can be self-checked in synthesized designs.

Parameters:
EXP_TT, 4'b0110, expected truth table; bit {a,b} holds the expected y for that input pair (a is the MSB). The default is XOR.
SETTLE, 2, cycles each vector is held before sampling. Legal range is 1..15; values outside it are a synthesis error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to run a check; honoured only in IDLE or DONE
dut_y  input  1  DUT output, combinational from a/b
a  output  1  DUT input a (registered)
b  output  1  DUT input b (registered)
busy  output  1  high from the cycle after start acceptance until the last sample completes
done  output  1  level; high in DONE until the next accepted start or reset
pass  output  1  equals (fail_vec==0) while done=1; 0 otherwise
err_count  output  3  number of mismatching vectors, 0..4
fail_vec  output  4  bit i set if the vector with {a,b}=i mismatched

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, a=b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, idx=0, settle counter=0. Reset mid-run aborts immediately. No partial result is retained.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE or DONE with start=1 at an edge:
  - idx=0, a=0, b=0
  - fail_vec=0, err_count=0, done=0, pass=0
  - cnt=SETTLE-1, busy=1
  - go to DRIVE.
- DRIVE: hold a/b = idx. Decrement cnt each cycle. When cnt==0, go to SAMPLE. DRIVE lasts exactly SETTLE cycles.
- SAMPLE (one cycle): compare dut_y with EXP_TT[idx] in that cycle. On mismatch, set fail_vec[idx] and increment err_count at the edge leaving SAMPLE. Then:
  - If idx<3: idx=idx+1, a/b updated to the new idx at the same edge, cnt=SETTLE-1, go to DRIVE.
  - If idx==3: go to DONE; busy=0, done=1, pass=(final fail_vec==0), a=b=0.
- Latency: done rises 4*(SETTLE+1) cycles after the edge that accepted start. The default is 12.
- start while busy (DRIVE/SAMPLE) is ignored and has no effect on the run.
- start held high continuously: in DONE it is accepted once per completed run, so checks run back-to-back.
- a/b change only on edges entering DRIVE for a new vector. They never change during DRIVE or SAMPLE, so sampling is always ≥SETTLE cycles after the last input change.
- err_count never wraps (max 4). fail_vec and err_count are stable and readable throughout DONE.
- dut_y is assumed synchronous to clk via the combinational DUT. No synchronizer is included.

Test Plan:
- XOR DUT (y=a^b), defaults, pulse start: a/b sequence 00,01,10,11, each held 3 cycles; done=1 at cycle 12; pass=1, err_count=0, fail_vec=4'b0000.
- dut_y tied 0, defaults: done at cycle 12; fail_vec=4'b0110, err_count=2, pass=0.
- AND DUT with default EXP_TT: fail_vec=4'b1110, err_count=3, pass=0. Then rerun with EXP_TT=4'b1000: pass=1, fail_vec=0.
- XOR DUT, start pulsed again at cycles 3 and 7 mid-run: ignored; done still at cycle 12 with pass=1. After DONE, a new start clears done/pass/fail_vec on the next edge and reruns.
- Reset asserted asynchronously mid-DRIVE of vector 2 (between edges): all outputs return to 0 immediately. After release, done stays 0 until a new start, and the full run then completes in 12 cycles.
- SETTLE=1 with XOR DUT: each vector held 2 cycles; done at cycle 8; pass=1.

Source files
------------

// File: rtl/gate_truth_table_checker.sv
// Drives a 2-input gate through all four input pairs and checks its
// output against an expected truth table after a settle window.
module gate_truth_table_checker #(
  parameter logic [3:0] EXP_TT = 4'b0110,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("SETTLE must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic       miss;
  logic [3:0] fail_nxt;
  logic [1:0] idx_inc;

  assign miss     = dut_y != EXP_TT[idx];
  assign fail_nxt = fail_vec | ({3'b000, miss} << idx);
  assign idx_inc  = idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 4'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            idx       <= 2'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            fail_vec  <= 4'd0;
            err_count <= 3'd0;
            done      <= 1'b0;
            pass      <= 1'b0;
            cnt       <= CNT_INIT;
            busy      <= 1'b1;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == 4'd0) state <= SAMPLE;
          else cnt <= cnt - 4'd1;
        end
        SAMPLE: begin
          fail_vec <= fail_nxt;
          if (miss) err_count <= err_count + 3'd1;
          if (idx == 2'd3) begin
            // pass must reflect this last sample too
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= fail_nxt == 4'd0;
            a     <= 1'b0;
            b     <= 1'b0;
          end else begin
            idx    <= idx_inc;
            {a, b} <= idx_inc;
            cnt    <= CNT_INIT;
            state  <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Randomised bench for gate_truth_table_checker: three instances with
// different EXP_TT/SETTLE, each fed by a table-driven fake gate.
module tb_gate_truth_table_checker;

  localparam int         S_P[3] = '{2, 2, 1};
  localparam logic [3:0] E_P[3] = '{4'b0110, 4'b1000, 4'b0110};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] tt[3];
  logic       y_i[3];
  logic       a_o[3];
  logic       b_o[3];
  logic       busy_o[3];
  logic       done_o[3];
  logic       pass_o[3];
  logic [2:0] err_o[3];
  logic [3:0] fv_o[3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign y_i[g] = tt[g][{a_o[g], b_o[g]}];
    gate_truth_table_checker #(
      .EXP_TT(E_P[g]),
      .SETTLE(S_P[g])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .dut_y    (y_i[g]),
      .a        (a_o[g]),
      .b        (b_o[g]),
      .busy     (busy_o[g]),
      .done     (done_o[g]),
      .pass     (pass_o[g]),
      .err_count(err_o[g]),
      .fail_vec (fv_o[g])
    );
  end

  function automatic logic [11:0] obs(int d);
    return {a_o[d], b_o[d], busy_o[d], done_o[d], pass_o[d],
            err_o[d], fv_o[d]};
  endfunction

  // Expected {a,b,busy,done,pass,err,fail} k edges after start accepted.
  function automatic logic [11:0] model_vec(int s, logic [3:0] e,
                                            logic [3:0] t, int k);
    logic [3:0] full;
    logic [3:0] part;
    int n;
    full = t ^ e;
    part = 4'd0;
    if (k >= 4 * (s + 1))
      return {2'b00, 1'b0, 1'b1, full == 4'd0,
              3'($countones(full)), full};
    n = k / (s + 1);
    for (int i = 0; i < n; i++) part[i] = full[i];
    return {2'(n), 1'b1, 1'b0, 1'b0, 3'($countones(part)), part};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs(d) !== 12'd0) begin
        n_bad++;
        $display("FAIL reset d%0d got=%b want=%b", d, obs(d), 12'd0);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs(d) !== 12'd0) begin
        n_bad++;
        $display("FAIL idle d%0d got=%b want=%b", d, obs(d), 12'd0);
      end
    end
  endtask

  task automatic test_run(string name, logic [3:0] t0, logic [3:0] t1,
                          logic [3:0] t2);
    tt[0] = t0;
    tt[1] = t1;
    tt[2] = t2;
    pulse_start();
    for (int k = 0; k <= 13; k++) begin
      for (int d = 0; d < 3; d++) begin
        logic [11:0] want;
        want = model_vec(S_P[d], E_P[d], tt[d], k);
        n_cmp++;
        if (obs(d) !== want) begin
          n_bad++;
          $display("FAIL %s d%0d k%0d got=%b want=%b",
                   name, d, k, obs(d), want);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    tt[0] = 4'b0110;
    tt[1] = 4'b0110;
    tt[2] = 4'b0110;
    pulse_start();
    for (int k = 0; k <= 12; k++) begin
      logic [11:0] want;
      want = model_vec(S_P[0], E_P[0], tt[0], k);
      n_cmp++;
      if (obs(0) !== want) begin
        n_bad++;
        $display("FAIL ignore k%0d got=%b want=%b", k, obs(0), want);
      end
      start = (k == 2 || k == 6);
      @(negedge clk);
    end
    start = 1'b0;
    // restart from DONE clears results at the accepting edge
    tt[0] = 4'b0000;
    pulse_start();
    n_cmp++;
    if (obs(0) !== model_vec(S_P[0], E_P[0], tt[0], 0)) begin
      n_bad++;
      $display("FAIL restart got=%b want=%b", obs(0),
               model_vec(S_P[0], E_P[0], tt[0], 0));
    end
    repeat (13) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    tt[0] = 4'b0110;
    pulse_start();
    repeat (6) @(negedge clk);
    n_cmp++;
    if (obs(0) !== model_vec(2, E_P[0], tt[0], 6)) begin
      n_bad++;
      $display("FAIL pre_rst got=%b want=%b", obs(0),
               model_vec(2, E_P[0], tt[0], 6));
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs(d) !== 12'd0) begin
        n_bad++;
        $display("FAIL async_rst d%0d got=%b want=%b", d, obs(d), 12'd0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (obs(0) !== 12'd0) begin
      n_bad++;
      $display("FAIL post_rst got=%b want=%b", obs(0), 12'd0);
    end
    pulse_start();
    for (int k = 0; k <= 12; k++) begin
      n_cmp++;
      if (obs(0) !== model_vec(2, E_P[0], tt[0], k)) begin
        n_bad++;
        $display("FAIL rerun k%0d got=%b want=%b", k, obs(0),
                 model_vec(2, E_P[0], tt[0], k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    tt[0] = 4'b0110;
    start = 1'b1;
    @(negedge clk);
    // accepted once per run: DONE lasts one cycle, period 13
    for (int k = 0; k < 26; k++) begin
      n_cmp++;
      if (obs(0) !== model_vec(2, E_P[0], tt[0], k % 13)) begin
        n_bad++;
        $display("FAIL b2b k%0d got=%b want=%b", k, obs(0),
                 model_vec(2, E_P[0], tt[0], k % 13));
      end
      if (k == 25) start = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (obs(0) !== model_vec(2, E_P[0], tt[0], 12)) begin
      n_bad++;
      $display("FAIL b2b_hold got=%b want=%b", obs(0),
               model_vec(2, E_P[0], tt[0], 12));
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      test_run("rand", 4'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  initial begin
    tt[0] = 4'b0110;
    tt[1] = 4'b0110;
    tt[2] = 4'b0110;
    @(negedge clk);
    test_reset();
    test_run("xor", 4'b0110, 4'b0110, 4'b0110);
    test_run("zero", 4'b0000, 4'b0000, 4'b0000);
    test_run("and", 4'b1000, 4'b1000, 4'b1000);
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
